// File: rtl/move_sequencer_pkg.sv
// Shared types for the move sequencer: command record, sequencer states and fault codes.
package move_sequencer_pkg;

    typedef struct packed {
        logic [4:0][31:0]        speed;
        logic signed [4:0][31:0] num;
    } move_cmd_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        GAP   = 3'd3,
        FAULT = 3'd4
    } seq_state_t;

    localparam logic [1:0] FC_NONE    = 2'd0;
    localparam logic [1:0] FC_ENGINE  = 2'd1;
    localparam logic [1:0] FC_TIMEOUT = 2'd2;

endpackage

// File: rtl/move_sequencer_if.sv
// Command-side valid/ready channel carrying one move (step counts and speeds for five axes).
interface move_sequencer_if;

    logic         cmd_valid;
    logic         cmd_ready;
    logic [159:0] cmd_num;
    logic [159:0] cmd_speed;

    modport master (
        output cmd_valid,
        output cmd_num,
        output cmd_speed,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_num,
        input  cmd_speed,
        output cmd_ready
    );

endinterface

// File: rtl/move_sequencer_fifo.sv
// Synchronous FIFO of move commands; flush clears pointers and count in one edge.
module move_sequencer_fifo
    import move_sequencer_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  move_cmd_t                    wr_data,
    output move_cmd_t                    rd_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);

    move_cmd_t     mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/move_sequencer.sv
// Queues move commands and hands them one at a time to the motion engine, enforcing a
// minimum idle gap between moves and latching engine errors or run timeouts.
//
// state | meaning
// IDLE  | waiting; pops the FIFO head into move_* when something is queued
// LOAD  | one cycle with move_* stable before start is raised
// RUN   | start_driving high, waiting for engine finish / error / timeout
// GAP   | start low for GAP_CYCLES cycles between moves
// FAULT | engine error or timeout latched; waits for clear_fault
module move_sequencer
    import move_sequencer_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int GAP_CYCLES = 4,
    parameter int TIMEOUT    = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    move_sequencer_if.slave              cmd,
    input  logic                         abort,
    input  logic                         clear_fault,
    input  logic                         eng_finish,
    input  logic                         eng_error,
    output logic [159:0]                 move_num,
    output logic [159:0]                 move_speed,
    output logic                         start_driving,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic [31:0]                  moves_done,
    output logic                         fault,
    output logic [1:0]                   fault_code
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);
    localparam logic [31:0]   TMO_LOAD = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;
    localparam bit            TMO_EN   = (TIMEOUT > 0);

    localparam logic [2:0] S_IDLE  = IDLE;
    localparam logic [2:0] S_LOAD  = LOAD;
    localparam logic [2:0] S_RUN   = RUN;
    localparam logic [2:0] S_GAP   = GAP;
    localparam logic [2:0] S_FAULT = FAULT;

    logic [2:0]    state;
    logic [GW-1:0] gap_cnt;
    logic [31:0]   tmo_cnt;
    move_cmd_t     head;
    move_cmd_t     wr_cmd;
    logic          push;
    logic          pop;

    assign wr_cmd.num   = cmd.cmd_num;
    assign wr_cmd.speed = cmd.cmd_speed;

    assign cmd.cmd_ready = (fifo_count != CW'(DEPTH)) && (state != S_FAULT);

    // abort wins over a same-cycle push and over the idle pop
    assign push = cmd.cmd_valid && cmd.cmd_ready && !abort;
    assign pop  = (state == S_IDLE) && (fifo_count != '0) && !abort;

    move_sequencer_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .flush   (abort),
        .wr_data (wr_cmd),
        .rd_data (head),
        .count   (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            gap_cnt    <= '0;
            tmo_cnt    <= '0;
            move_num   <= '0;
            move_speed <= '0;
            moves_done <= '0;
            fault_code <= FC_NONE;
        end else if (abort) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        move_num   <= head.num;
                        move_speed <= head.speed;
                        fault_code <= FC_NONE;
                        state      <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    tmo_cnt <= TMO_LOAD;
                    state   <= S_RUN;
                end
                S_RUN: begin
                    if (eng_error) begin
                        fault_code <= FC_ENGINE;
                        state      <= S_FAULT;
                    end else if (eng_finish) begin
                        moves_done <= moves_done + 32'd1;
                        gap_cnt    <= GAP_LOAD;
                        state      <= S_GAP;
                    end else if (TMO_EN && (tmo_cnt == '0)) begin
                        fault_code <= FC_TIMEOUT;
                        state      <= S_FAULT;
                    end else begin
                        tmo_cnt <= tmo_cnt - 32'd1;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == '0) begin
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                S_FAULT: begin
                    if (clear_fault) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign start_driving = (state == S_RUN);
    assign fault         = (state == S_FAULT);
    assign busy          = (state != S_IDLE) || (fifo_count != '0);

endmodule
